// File: rtl/snake_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : snake_pkg                                                  |
// | Description : Shared definitions for the snake motion path: game status  |
// |               codes (common with the control unit), direction encoding,  |
// |               default grid/timing constants and a direction helper.      |
// | Ports       : none (package)                                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package snake_pkg;

  // Game status codes driven by the control unit
  localparam logic [1:0] RESTART = 2'b00;
  localparam logic [1:0] START   = 2'b01;
  localparam logic [1:0] PLAY    = 2'b10;
  localparam logic [1:0] DIE     = 2'b11;

  // Directions are paired so that flipping bit 0 gives the opposite one
  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  // Default geometry and timing
  localparam int GRID_W_DEF     = 40;
  localparam int GRID_H_DEF     = 30;
  localparam int X_W_DEF        = 6;
  localparam int Y_W_DEF        = 5;
  localparam int MAX_LEN_DEF    = 16;
  localparam int INIT_LEN_DEF   = 3;
  localparam int MOVE_TICKS_DEF = 12_500_000;
  localparam int LEN_W          = 5;

  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage : snake_pkg
`default_nettype wire

// File: rtl/snake_step_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : snake_step_timer                                           |
// | Description : Free-running move counter. Counts while en is high, wraps  |
// |               at MOVE_TICKS-1 and emits tick in the wrap cycle.          |
// | Ports       : clk, rst (async, active-low), en (count enable),           |
// |               clr (sync clear, dominates en), tick (one-cycle pulse)     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module snake_step_timer
  import snake_pkg::*;
#(
  parameter int MOVE_TICKS = MOVE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W  = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(MOVE_TICKS - 1);

  logic [CNT_W-1:0] r_cnt;

  // Combinational so the step executes in the same cycle the counter wraps
  assign tick = en & ~clr & (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule : snake_step_timer
`default_nettype wire

// File: rtl/snake_motion_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : snake_motion_unit                                          |
// | Description : Snake position/direction/length state, wall and body       |
// |               collision detection, and the pixel-cell head/body query.   |
// | Ports       : clk, rst (async, active-low)                               |
// |               key1..4_press  direction requests UP/DOWN/LEFT/RIGHT       |
// |               game_status    control-unit status, restart (active-low)   |
// |               grow           apple eaten pulse                           |
// |               pix_x/pix_y    query cell; on_head/on_body answer (reg)    |
// |               hit_wall/hit_body sticky collision events                  |
// |               head_x/head_y, body_len, step (move pulse)                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module snake_motion_unit
  import snake_pkg::*;
#(
  parameter int GRID_W     = GRID_W_DEF,
  parameter int GRID_H     = GRID_H_DEF,
  parameter int X_W        = X_W_DEF,
  parameter int Y_W        = Y_W_DEF,
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int INIT_LEN   = INIT_LEN_DEF,
  parameter int MOVE_TICKS = MOVE_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key1_press,
  input  logic             key2_press,
  input  logic             key3_press,
  input  logic             key4_press,
  input  logic [1:0]       game_status,
  input  logic             restart,
  input  logic             grow,
  input  logic [X_W-1:0]   pix_x,
  input  logic [Y_W-1:0]   pix_y,
  output logic             hit_wall,
  output logic             hit_body,
  output logic             on_head,
  output logic             on_body,
  output logic [X_W-1:0]   head_x,
  output logic [Y_W-1:0]   head_y,
  output logic [LEN_W-1:0] body_len,
  output logic             step
);

  localparam logic [LEN_W-1:0] c_max_len  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] c_init_len = LEN_W'(INIT_LEN);
  localparam logic [X_W-1:0]   c_x_last   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   c_y_last   = Y_W'(GRID_H - 1);

  // Segment 0 is the head; segments at index >= length are don't-care
  function automatic logic [X_W-1:0] init_x(input int i);
    return (i < INIT_LEN) ? X_W'(GRID_W / 2 - i) : '0;
  endfunction

  function automatic logic [Y_W-1:0] init_y(input int i);
    return (i < INIT_LEN) ? Y_W'(GRID_H / 2) : '0;
  endfunction

  logic [X_W-1:0]   r_seg_x [MAX_LEN];
  logic [Y_W-1:0]   r_seg_y [MAX_LEN];
  dir_t             r_dir, r_pend_dir;
  logic             r_pend_valid, r_grow_pend;
  logic [LEN_W-1:0] r_len;
  logic             r_hit_wall, r_hit_body, r_step, r_on_head, r_on_body;

  logic             w_play, w_tmr_clr, w_tick, w_active;
  logic             w_req_valid, w_req_ok, w_wall, w_body_hit, w_move, w_grow_eff;
  dir_t             w_req_dir, w_step_dir, w_commit_dir;
  logic [X_W-1:0]   w_next_x;
  logic [Y_W-1:0]   w_next_y;
  logic [LEN_W-1:0] w_cmp_len;
  logic [MAX_LEN-1:0] w_hit_vec, w_qb_vec;

  assign w_play    = (game_status == PLAY);
  assign w_tmr_clr = ~restart | ~w_play;

  snake_step_timer #(
    .MOVE_TICKS (MOVE_TICKS)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (w_play),
    .clr  (w_tmr_clr),
    .tick (w_tick)
  );

  // Once a collision is flagged the snake is frozen until reinit
  assign w_active   = w_tick & ~r_hit_wall & ~r_hit_body;
  assign w_step_dir = r_pend_valid ? r_pend_dir : r_dir;

  // Growth only counts if there is room; at full length the tail still vacates
  assign w_grow_eff = (r_grow_pend | grow) & (r_len < c_max_len);
  assign w_cmp_len  = w_grow_eff ? r_len : r_len - LEN_W'(1);

  always_comb begin
    w_req_valid = key1_press | key2_press | key3_press | key4_press;
    if (key1_press)      w_req_dir = UP;
    else if (key2_press) w_req_dir = DOWN;
    else if (key3_press) w_req_dir = LEFT;
    else                 w_req_dir = RIGHT;
  end

  always_comb begin
    w_next_x = r_seg_x[0];
    w_next_y = r_seg_y[0];
    w_wall   = 1'b0;
    case (w_step_dir)
      UP:    begin w_wall = (r_seg_y[0] == '0);       w_next_y = r_seg_y[0] - Y_W'(1); end
      DOWN:  begin w_wall = (r_seg_y[0] == c_y_last); w_next_y = r_seg_y[0] + Y_W'(1); end
      LEFT:  begin w_wall = (r_seg_x[0] == '0);       w_next_x = r_seg_x[0] - X_W'(1); end
      default: begin w_wall = (r_seg_x[0] == c_x_last); w_next_x = r_seg_x[0] + X_W'(1); end
    endcase
  end

  // Per-segment comparators: next-head collision and pixel body query
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    assign w_hit_vec[i] = (LEN_W'(i) < w_cmp_len) &&
                          (r_seg_x[i] == w_next_x) && (r_seg_y[i] == w_next_y);
    if (i == 0) begin : g_head
      assign w_qb_vec[i] = 1'b0;
    end else begin : g_body
      assign w_qb_vec[i] = (LEN_W'(i) < r_len) &&
                           (r_seg_x[i] == pix_x) && (r_seg_y[i] == pix_y);
    end
  end

  assign w_body_hit = |w_hit_vec;
  assign w_move     = w_active & ~w_wall & ~w_body_hit;

  // Reversal is judged against the direction in force after this cycle
  assign w_commit_dir = w_move ? w_step_dir : r_dir;
  assign w_req_ok     = w_req_valid & (w_req_dir != opposite(w_commit_dir));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= init_x(i);
        r_seg_y[i] <= init_y(i);
      end
    end else if (!restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= init_x(i);
        r_seg_y[i] <= init_y(i);
      end
    end else if (w_move) begin
      for (int i = MAX_LEN - 1; i >= 1; i--) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
      r_seg_x[0] <= w_next_x;
      r_seg_y[0] <= w_next_y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir        <= RIGHT;
      r_pend_dir   <= RIGHT;
      r_pend_valid <= 1'b0;
      r_grow_pend  <= 1'b0;
      r_len        <= c_init_len;
      r_hit_wall   <= 1'b0;
      r_hit_body   <= 1'b0;
      r_step       <= 1'b0;
      r_on_head    <= 1'b0;
      r_on_body    <= 1'b0;
    end else if (!restart) begin
      r_dir        <= RIGHT;
      r_pend_dir   <= RIGHT;
      r_pend_valid <= 1'b0;
      r_grow_pend  <= 1'b0;
      r_len        <= c_init_len;
      r_hit_wall   <= 1'b0;
      r_hit_body   <= 1'b0;
      r_step       <= 1'b0;
      r_on_head    <= 1'b0;
      r_on_body    <= 1'b0;
    end else begin
      r_step    <= w_move;
      r_on_head <= (r_seg_x[0] == pix_x) && (r_seg_y[0] == pix_y);
      r_on_body <= |w_qb_vec;
      if (w_move) r_dir <= w_step_dir;
      if (w_req_ok) begin
        r_pend_dir   <= w_req_dir;
        r_pend_valid <= 1'b1;
      end else if (w_move) begin
        r_pend_valid <= 1'b0;
      end
      if (w_move)     r_grow_pend <= 1'b0;
      else if (grow)  r_grow_pend <= (r_len < c_max_len);
      if (w_move && w_grow_eff) r_len <= r_len + LEN_W'(1);
      if (w_active && w_wall) r_hit_wall <= 1'b1;
      if (w_active && !w_wall && w_body_hit) r_hit_body <= 1'b1;
    end
  end

  assign hit_wall = r_hit_wall;
  assign hit_body = r_hit_body;
  assign on_head  = r_on_head;
  assign on_body  = r_on_body;
  assign head_x   = r_seg_x[0];
  assign head_y   = r_seg_y[0];
  assign body_len = r_len;
  assign step     = r_step;

endmodule : snake_motion_unit
`default_nettype wire

// File: tb/tb_snake_motion_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_snake_motion_unit                                       |
// | Description : Directed bench for snake_motion_unit on an 8x6 grid with a |
// |               4-cycle move period. Instance a has MAX_LEN 16, instance b |
// |               MAX_LEN 4; both share all inputs.                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_snake_motion_unit;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] keys = '0;
  logic [1:0] game_status = START;
  logic       restart = 1'b1;
  logic       grow = 1'b0;
  logic [5:0] pix_x = '0;
  logic [4:0] pix_y = '0;

  logic       a_hit_wall, a_hit_body, a_on_head, a_on_body, a_step;
  logic [5:0] a_head_x;
  logic [4:0] a_head_y, a_len;
  logic       b_hit_wall, b_hit_body, b_on_head, b_on_body, b_step;
  logic [5:0] b_head_x;
  logic [4:0] b_head_y, b_len;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  snake_motion_unit #(
    .GRID_W(8), .GRID_H(6), .X_W(6), .Y_W(5),
    .MAX_LEN(16), .INIT_LEN(3), .MOVE_TICKS(4)
  ) dut_a (
    .clk(clk), .rst(rst),
    .key1_press(keys[0]), .key2_press(keys[1]), .key3_press(keys[2]), .key4_press(keys[3]),
    .game_status(game_status), .restart(restart), .grow(grow),
    .pix_x(pix_x), .pix_y(pix_y),
    .hit_wall(a_hit_wall), .hit_body(a_hit_body), .on_head(a_on_head), .on_body(a_on_body),
    .head_x(a_head_x), .head_y(a_head_y), .body_len(a_len), .step(a_step)
  );

  snake_motion_unit #(
    .GRID_W(8), .GRID_H(6), .X_W(6), .Y_W(5),
    .MAX_LEN(4), .INIT_LEN(3), .MOVE_TICKS(4)
  ) dut_b (
    .clk(clk), .rst(rst),
    .key1_press(keys[0]), .key2_press(keys[1]), .key3_press(keys[2]), .key4_press(keys[3]),
    .game_status(game_status), .restart(restart), .grow(grow),
    .pix_x(pix_x), .pix_y(pix_y),
    .hit_wall(b_hit_wall), .hit_body(b_hit_body), .on_head(b_on_head), .on_body(b_on_body),
    .head_x(b_head_x), .head_y(b_head_y), .body_len(b_len), .step(b_step)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_head_a(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(a_head_x), 32'(x));
    check({tag, "_y"}, 32'(a_head_y), 32'(y));
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k);
    keys = 4'b0001 << (k - 1);
    cyc(1);
    keys = '0;
  endtask

  task automatic pulse_grow();
    grow = 1'b1;
    cyc(1);
    grow = 1'b0;
  endtask

  task automatic do_restart(input logic [1:0] st);
    game_status = RESTART;
    restart = 1'b0;
    cyc(3);
    restart = 1'b1;
    game_status = st;
  endtask

  initial begin
    // Reset state
    cyc(2);
    check_head_a("rst_head", 4, 3);
    check("rst_len", 32'(a_len), 3);
    check("rst_wall", 32'(a_hit_wall), 0);
    check("rst_body", 32'(a_hit_body), 0);
    check("rst_step", 32'(a_step), 0);
    check("rst_onhead", 32'(a_on_head), 0);
    check("rst_onbody", 32'(a_on_body), 0);
    check("rst_b_len", 32'(b_len), 3);

    // 1: first step after four PLAY cycles
    rst = 1'b1;
    game_status = PLAY;
    cyc(3);
    check("t1_nostep", 32'(a_step), 0);
    cyc(1);
    check("t1_step", 32'(a_step), 1);
    check_head_a("t1_head", 5, 3);
    check("t1_len", 32'(a_len), 3);
    game_status = START;
    pix_x = 6'd4; pix_y = 5'd3;
    cyc(1);
    check("t1_step_off", 32'(a_step), 0);
    check("t1_seg1", 32'(a_on_body), 1);
    pix_x = 6'd3;
    cyc(1);
    check("t1_seg2", 32'(a_on_body), 1);
    pix_x = 6'd2;
    cyc(1);
    check("t1_vacated", 32'(a_on_body), 0);
    pix_x = 6'd5;
    cyc(1);
    check("t1_q_head", 32'(a_on_head), 1);
    check("t1_q_head_nb", 32'(a_on_body), 0);

    // 2: reversal discarded, later request kept
    do_restart(PLAY);
    press(3);
    press(1);
    cyc(2);
    check("t2_step", 32'(a_step), 1);
    check_head_a("t2_head", 4, 2);

    // 3: run into the right wall
    do_restart(PLAY);
    check_head_a("t3_init", 4, 3);
    cyc(12);
    check_head_a("t3_edge", 7, 3);
    cyc(4);
    check("t3_wall", 32'(a_hit_wall), 1);
    check("t3_nostep", 32'(a_step), 0);
    check_head_a("t3_stay", 7, 3);
    cyc(8);
    check("t3_sticky", 32'(a_hit_wall), 1);
    check_head_a("t3_frozen", 7, 3);
    do_restart(START);
    check("t3_clear", 32'(a_hit_wall), 0);
    check_head_a("t3_reinit", 4, 3);
    check("t3_len", 32'(a_len), 3);

    // 4: grow to 5, then curl back into own body
    do_restart(PLAY);
    pulse_grow();
    cyc(3);
    check("t4_len4", 32'(a_len), 4);
    pulse_grow();
    cyc(3);
    check("t4_len5", 32'(a_len), 5);
    check_head_a("t4_h2", 6, 3);
    cyc(4);
    check_head_a("t4_right", 7, 3);
    press(1);
    cyc(3);
    check_head_a("t4_up", 7, 2);
    press(3);
    cyc(3);
    check_head_a("t4_left", 6, 2);
    press(2);
    cyc(3);
    check("t4_hitbody", 32'(a_hit_body), 1);
    check("t4_nowall", 32'(a_hit_wall), 0);
    check("t4_nostep", 32'(a_step), 0);
    check_head_a("t4_stay", 6, 2);

    // 4b: chasing the tail with length 4 is legal
    do_restart(PLAY);
    pulse_grow();
    cyc(3);
    press(1);
    cyc(3);
    press(3);
    cyc(3);
    check_head_a("t4b_pre", 4, 2);
    press(2);
    cyc(3);
    check("t4b_nohit", 32'(a_hit_body), 0);
    check("t4b_step", 32'(a_step), 1);
    check_head_a("t4b_tail", 4, 3);

    // 5: keys in START are latched but no motion happens
    do_restart(START);
    for (int i = 0; i < 20; i++) begin
      press((i % 2 == 0) ? 4 : 1);
      check("t5_nostep", 32'(a_step), 0);
    end
    check_head_a("t5_hold", 4, 3);
    game_status = PLAY;
    cyc(4);
    check("t5_step", 32'(a_step), 1);
    check_head_a("t5_up", 4, 2);

    // 6: length saturation on instance b
    do_restart(START);
    for (int i = 0; i < 20; i++) pulse_grow();
    game_status = PLAY;
    cyc(4);
    check("t6_len4", 32'(b_len), 4);
    game_status = START;
    for (int i = 0; i < 20; i++) pulse_grow();
    game_status = PLAY;
    cyc(4);
    check("t6_sat", 32'(b_len), 4);
    check("t6_b_step", 32'(b_step), 1);
    game_status = START;
    pix_x = 6'd3; pix_y = 5'd3;
    cyc(1);
    check("t6_tail", 32'(b_on_body), 1);
    pix_x = 6'd2;
    cyc(1);
    check("t6_vacated", 32'(b_on_body), 0);
    pix_x = 6'd6;
    cyc(1);
    check("t6_head", 32'(b_on_head), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_snake_motion_unit
`default_nettype wire
